pq_test_sequencer: RTL and testbench

- Self-test controller for the priority-queue datapath.
- On `start`, fills the queue with pseudo-random values, then drains it.
- Checks that popped values come out in non-decreasing order, which is min-first priority.
- Counts ordering violations and reports a pass/fail verdict. It sits between the top-level test harness and the priority-queue core, and sequences the core's push/pop strobes.

---
 rtl/pq_ctrl_pkg.sv | 21 ++
 rtl/pq_test_sequencer_lfsr_gen.sv | 37 +++
 rtl/pq_test_sequencer.sv | 143 ++++++++++++++
 tb/tb_pq_test_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_ctrl_pkg.sv
// Shared types for the priority-queue self-test: FSM states, LFSR taps, saturating counter helper.
// Pure declarations; no latency or flow control of its own.
package pq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Galois (right-shift) masks: x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pq_test_sequencer_lfsr_gen.sv
// Maximal-length Galois LFSR, never zero; q is the current word, advances one step per enb.
// Zero latency from state to q; no backpressure, the caller gates enb.
module lfsr_gen
    import pq_ctrl_pkg::*;
#(
    parameter int             DW   = 8,
    parameter logic [DW-1:0]  SEED = {{(DW-1){1'b0}}, 1'b1}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    output logic [DW-1:0] q
);

    localparam logic [DW-1:0] TAPS = (DW == 16) ? DW'(LFSR_TAPS_16) : DW'(LFSR_TAPS_8);

    logic [DW-1:0] lfsr_q;
    logic [DW-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (enb) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/pq_test_sequencer.sv
// Self-test sequencer: fills the priority queue with LFSR data, drains it, counts ordering violations.
// Strobes are combinational from state; one pop outstanding, result read POP_LAT cycles later; stalls on pq_busy/pq_full.
module pq_test_sequencer
    import pq_ctrl_pkg::*;
#(
    parameter int             DW        = 8,
    parameter int             NUM_ITEMS = 16,
    parameter logic [DW-1:0]  LFSR_SEED = DW'(8'hA5),
    parameter int             POP_LAT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pq_full,
    input  logic          pq_empty,
    input  logic          pq_busy,
    input  logic [DW-1:0] pq_rdata,
    output logic          pq_push,
    output logic [DW-1:0] pq_wdata,
    output logic          pq_pop,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_count,
    output logic [7:0]    push_count,
    output logic [7:0]    pop_count
);

    localparam logic [7:0] NUM_ITEMS_C = 8'(NUM_ITEMS);
    localparam logic [1:0] LAT_LAST    = 2'(POP_LAT - 1);

    state_t        state_q, state_d;
    logic [7:0]    push_count_q, push_count_d;
    logic [7:0]    pop_count_q, pop_count_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          prev_valid_q, prev_valid_d;
    logic [1:0]    lat_cnt_q, lat_cnt_d;
    logic          push_s;
    logic          pop_s;
    logic [DW-1:0] lfsr_val;

    lfsr_gen #(
        .DW   (DW),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .enb (push_s),
        .q   (lfsr_val)
    );

    always_comb begin
        state_d      = state_q;
        push_count_d = push_count_q;
        pop_count_d  = pop_count_q;
        err_count_d  = err_count_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        lat_cnt_d    = lat_cnt_q;
        push_s       = 1'b0;
        pop_s        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    push_count_d = '0;
                    pop_count_d  = '0;
                    err_count_d  = '0;
                    prev_valid_d = 1'b0;
                    state_d      = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!pq_full && !pq_busy) begin
                    push_s       = 1'b1;
                    push_count_d = sat_inc8(push_count_q);
                    if (push_count_d == NUM_ITEMS_C) begin
                        state_d = ST_DRAIN;
                    end
                end else if (pq_full) begin
                    // A queue smaller than NUM_ITEMS ends the fill early; that is not a failure.
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pq_empty) begin
                    state_d = ST_DONE;
                end else if (!pq_busy) begin
                    pop_s     = 1'b1;
                    lat_cnt_d = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    pop_count_d = sat_inc8(pop_count_q);
                    if (prev_valid_q && (prev_q > pq_rdata)) begin
                        err_count_d = sat_inc8(err_count_q);
                    end
                    prev_d       = pq_rdata;
                    prev_valid_d = 1'b1;
                    state_d      = ST_DRAIN;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            push_count_q <= '0;
            pop_count_q  <= '0;
            err_count_q  <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            lat_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            push_count_q <= push_count_d;
            pop_count_q  <= pop_count_d;
            err_count_q  <= err_count_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            lat_cnt_q    <= lat_cnt_d;
        end
    end

    // Strobes decode from the async-reset state register, so they fall as soon as rst asserts.
    assign pq_push    = push_s;
    assign pq_pop     = pop_s;
    assign pq_wdata   = push_s ? lfsr_val : '0;
    assign busy       = (state_q == ST_FILL) || (state_q == ST_DRAIN) || (state_q == ST_WAIT);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_count_q == 8'd0) && (pop_count_q == push_count_q);
    assign err_count  = err_count_q;
    assign push_count = push_count_q;
    assign pop_count  = pop_count_q;

endmodule

// File: tb/tb_pq_test_sequencer.sv
// Directed bench: a behavioural min-queue drives the sequencer through normal, faulty, shallow,
// busy-toggling, mid-run reset and restart scenarios.
module tb_pq_test_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pq_full;
    logic       pq_empty;
    logic       pq_busy;
    logic [7:0] pq_rdata;
    logic       pq_push;
    logic [7:0] pq_wdata;
    logic       pq_pop;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] push_count;
    logic [7:0] pop_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Queue model state
    logic [7:0] qd[$];
    int         depth      = 16;
    bit         fault_mode = 0;
    bit         busy_mode  = 0;
    int         pop_idx    = 0;
    logic       pend_push  = 0;
    logic       pend_pop   = 0;
    logic [7:0] pend_wdata = 0;

    // Expected push data
    logic [7:0] exp_lfsr    = 8'hA5;
    bit         tab_mode    = 1;
    int         tab_idx     = 0;
    int         run_pushes  = 0;
    logic [7:0] first_wdata = 0;
    logic [7:0] tab [16] = '{8'hA5, 8'hEA, 8'h75, 8'h82, 8'h41, 8'h98, 8'h4C, 8'h26,
                             8'h13, 8'hB1, 8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07};

    pq_test_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pq_full    (pq_full),
        .pq_empty   (pq_empty),
        .pq_busy    (pq_busy),
        .pq_rdata   (pq_rdata),
        .pq_push    (pq_push),
        .pq_wdata   (pq_wdata),
        .pq_pop     (pq_pop),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .push_count (push_count),
        .pop_count  (pop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        pend_push  = pq_push;
        pend_pop   = pq_pop;
        pend_wdata = pq_wdata;
        if (pq_push || pq_pop) begin
            chk("push_pop_exclusive", {31'd0, pq_push & pq_pop}, 32'd0);
            chk("strobe_while_busy", {31'd0, pq_busy}, 32'd0);
        end
        if (pq_push) begin
            if (run_pushes == 0) first_wdata = pq_wdata;
            run_pushes++;
            chk("wdata_lfsr", {24'd0, pq_wdata}, {24'd0, exp_lfsr});
            if (tab_mode && tab_idx < 16) begin
                chk("wdata_table", {24'd0, pq_wdata}, {24'd0, tab[tab_idx]});
                tab_idx++;
            end
            exp_lfsr = lfsr_next(exp_lfsr);
        end
    end

    // Behavioural min-queue: applies the previous cycle's strobes just after each rising edge
    always begin
        @(posedge clk);
        #1;
        if (pend_push) begin
            int pos;
            pos = qd.size();
            for (int i = 0; i < qd.size(); i++) begin
                if (qd[i] > pend_wdata) begin
                    pos = i;
                    break;
                end
            end
            qd.insert(pos, pend_wdata);
        end
        if (pend_pop && qd.size() > 0) begin
            int sel;
            sel = (fault_mode && pop_idx == 3 && qd.size() > 1) ? 1 : 0;
            pq_rdata = qd[sel];
            qd.delete(sel);
            pop_idx++;
        end
        pq_full  = (qd.size() >= depth);
        pq_empty = (qd.size() == 0);
        pq_busy  = busy_mode ? ~pq_busy : 1'b0;
    end

    task automatic do_start();
        run_pushes = 0;
        pop_idx    = 0;
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !done; i++) @(negedge clk);
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_result(input string tag, input int e_push, input int e_pop,
                                input int e_err, input bit e_pass);
        chk({tag, "_push_count"}, {24'd0, push_count}, e_push);
        chk({tag, "_pop_count"}, {24'd0, pop_count}, e_pop);
        chk({tag, "_err_count"}, {24'd0, err_count}, e_err);
        chk({tag, "_pass"}, {31'd0, pass}, {31'd0, e_pass});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_push"}, {31'd0, pq_push}, 32'd0);
        chk({tag, "_pop"}, {31'd0, pq_pop}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, pq_wdata}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_err"}, {24'd0, err_count}, 32'd0);
        chk({tag, "_pushcnt"}, {24'd0, push_count}, 32'd0);
        chk({tag, "_popcnt"}, {24'd0, pop_count}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        pq_full  = 1'b0;
        pq_empty = 1'b1;
        pq_busy  = 1'b0;
        pq_rdata = 8'h00;

        repeat (3) @(posedge clk);
        #2 check_all_zero("reset");
        @(negedge clk) rst = 1'b1;

        // 1: normal run, data from the seed
        do_start();
        wait_done("run1_done", 500);
        check_result("run1", 16, 16, 0, 1'b1);
        chk("run1_pushes_seen", run_pushes, 16);

        // 2: restart from DONE with a queue that swaps one adjacent pair
        fault_mode = 1;
        tab_mode   = 0;
        do_start();
        chk("restart_done_drop", {31'd0, done}, 32'd0);
        chk("restart_push_clear", {24'd0, push_count}, 32'd0);
        chk("restart_err_clear", {24'd0, err_count}, 32'd0);
        wait_done("run2_done", 500);
        check_result("run2", 16, 16, 1, 1'b0);
        chk("run2_first_data", {24'd0, first_wdata}, 32'h0000_00BB);
        chk("run2_no_repeat", {31'd0, first_wdata == 8'hA5}, 32'd0);
        fault_mode = 0;

        // 3: queue of depth 10, fill stops on full
        depth = 10;
        do_start();
        wait_done("run3_done", 500);
        check_result("run3", 10, 10, 0, 1'b1);
        depth = 16;

        // 4: pq_busy toggling every cycle
        busy_mode = 1;
        do_start();
        wait_done("run4_done", 1000);
        check_result("run4", 16, 16, 0, 1'b1);
        busy_mode = 0;

        // 5: reset mid-drain after 5 pops
        do_start();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (pop_count == 8'd5) break;
        end
        chk("run5_reached_5_pops", {24'd0, pop_count}, 32'd5);
        rst = 1'b0;
        #1 check_all_zero("midrun_reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        qd.delete();
        pq_full   = 1'b0;
        pq_empty  = 1'b1;
        pend_push = 1'b0;
        pend_pop  = 1'b0;
        exp_lfsr  = 8'hA5;
        tab_mode  = 1;
        tab_idx   = 0;
        @(negedge clk) rst = 1'b1;

        // 6: clean run after reset, LFSR back at the seed
        do_start();
        wait_done("run6_done", 500);
        check_result("run6", 16, 16, 0, 1'b1);
        chk("run6_first_data", {24'd0, first_wdata}, 32'h0000_00A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
